// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_pkg
// Description : Shared register-file parameters and the writeback request
//               record carried from the aux requester to the register file.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    // One register-file write: destination plus data.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

endpackage : rv_pkg
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo
// Description : Synchronous FIFO of wb_req_t used to buffer late aux
//               writebacks. Every storage slot and its valid bit are
//               visible so the parent can build a pending-destination mask.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               push_i/push_data_i - enqueue (ignored while full)
//               pop_i              - dequeue head (ignored while empty)
//               head_o             - oldest entry
//               full_o/empty_o     - occupancy flags
//               count_o            - current occupancy
//               entries_o/valid_o  - raw storage and per-slot valid bits
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo
    import rv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push_i,
    input  wb_req_t                       push_data_i,
    input  logic                          pop_i,
    output wb_req_t                       head_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [$clog2(DEPTH):0]        count_o,
    output wb_req_t [DEPTH-1:0]           entries_o,
    output logic    [DEPTH-1:0]           valid_o
);

    localparam int PTR_W = $clog2(DEPTH);

    wb_req_t [DEPTH-1:0]    mem_q;
    logic    [DEPTH-1:0]    valid_q;
    logic    [PTR_W-1:0]    wr_ptr_q;
    logic    [PTR_W-1:0]    rd_ptr_q;
    logic    [PTR_W:0]      count_q;
    logic    [PTR_W:0]      count_d;

    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_pop;

    assign w_full  = (count_q == (PTR_W+1)'(DEPTH));
    assign w_empty = (count_q == '0);
    // Fullness is judged before any same-cycle pop, so a full FIFO never
    // accepts a push even while it is draining.
    assign w_push  = push_i & ~w_full;
    assign w_pop   = pop_i & ~w_empty;

    always_comb begin
        count_d = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two. When a push
    // and a pop coincide the FIFO is neither full nor empty, so the two
    // pointers address different slots.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            if (w_pop) begin
                valid_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q          <= rd_ptr_q + 1'b1;
            end
            if (w_push) begin
                valid_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q          <= wr_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    // Data storage needs no reset; the valid bits qualify it.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o    = mem_q[rd_ptr_q];
    assign full_o    = w_full;
    assign empty_o   = w_empty;
    assign count_o   = count_q;
    assign entries_o = mem_q;
    assign valid_o   = valid_q;

endmodule : wb_fifo
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Shares the single register-file write port between the
//               core's single-cycle writeback and a buffered auxiliary
//               requester. The core normally wins; a starvation counter
//               forces an aux drain (stalling the core one cycle) after the
//               FIFO has lost STARVE_LIMIT consecutive arbitrations.
// Ports       : clk, rst                        - clock, sync active-high reset
//               core_wr_valid/core_rd/core_data - core writeback request
//               core_stall                      - core write not performed
//               aux_valid/aux_rd/aux_data       - aux result offer
//               aux_ready                       - FIFO can accept
//               ru_wr/ru_rd/ru_data             - register-file write port
//               pend_mask                       - rd targets held in FIFO
//               fifo_count                      - FIFO occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter
    import rv_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int FIFO_DEPTH   = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          core_wr_valid,
    input  logic [REG_ADDR_W-1:0]         core_rd,
    input  logic [XLEN-1:0]               core_data,
    output logic                          core_stall,
    input  logic                          aux_valid,
    input  logic [REG_ADDR_W-1:0]         aux_rd,
    input  logic [XLEN-1:0]               aux_data,
    output logic                          aux_ready,
    output logic                          ru_wr,
    output logic [REG_ADDR_W-1:0]         ru_rd,
    output logic [XLEN-1:0]               ru_data,
    output logic [NUM_REGS-1:0]           pend_mask,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int              STARVE_W   = 4;
    localparam logic [STARVE_W-1:0] C_STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    wb_req_t                        w_push_data;
    wb_req_t                        w_head;
    wb_req_t [FIFO_DEPTH-1:0]       w_entries;
    logic    [FIFO_DEPTH-1:0]       w_valid;
    logic                           w_full;
    logic                           w_empty;
    logic    [$clog2(FIFO_DEPTH):0] w_count;

    logic                           w_core_eff;
    logic                           w_starved;
    logic                           w_grant_core;
    logic                           w_grant_aux;
    logic                           w_push;
    logic    [NUM_REGS-1:0]         w_pend;

    logic    [STARVE_W-1:0]         starve_q;
    logic    [STARVE_W-1:0]         starve_d;

    // ------------------------------------------------------------------
    // Aux buffer
    // ------------------------------------------------------------------
    // aux_ready depends only on registered occupancy (and reset). Writes to
    // x0 complete the handshake but are dropped rather than stored.
    assign aux_ready   = ~rst & ~w_full;
    assign w_push      = aux_valid & aux_ready & (aux_rd != '0);
    assign w_push_data = '{rd: aux_rd, data: aux_data};

    wb_fifo #(
        .DEPTH       (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (w_push),
        .push_data_i (w_push_data),
        .pop_i       (w_grant_aux),
        .head_o      (w_head),
        .full_o      (w_full),
        .empty_o     (w_empty),
        .count_o     (w_count),
        .entries_o   (w_entries),
        .valid_o     (w_valid)
    );

    // ------------------------------------------------------------------
    // Grant
    // ------------------------------------------------------------------
    // A core write to x0 is a no-op for the register file, so it neither
    // occupies the port nor can be stalled.
    assign w_core_eff   = core_wr_valid & (core_rd != '0);
    assign w_starved    = (starve_q == C_STARVE_MAX);
    assign w_grant_core = ~rst & w_core_eff & (w_empty | ~w_starved);
    assign w_grant_aux  = ~rst & ~w_empty & (~w_core_eff | w_starved);
    assign core_stall   = ~rst & w_core_eff & ~w_empty & w_starved;

    always_comb begin
        ru_wr   = 1'b0;
        ru_rd   = '0;
        ru_data = '0;
        if (w_grant_aux) begin
            ru_wr   = 1'b1;
            ru_rd   = w_head.rd;
            ru_data = w_head.data;
        end else if (w_grant_core) begin
            ru_wr   = 1'b1;
            ru_rd   = core_rd;
            ru_data = core_data;
        end
    end

    // ------------------------------------------------------------------
    // Starvation counter: counts consecutive losses of a non-empty FIFO.
    // ------------------------------------------------------------------
    always_comb begin
        starve_d = starve_q;
        if (w_empty || w_grant_aux) begin
            starve_d = '0;
        end else if (w_grant_core && !w_starved) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    // ------------------------------------------------------------------
    // Pending-destination mask; duplicate targets simply OR together.
    // ------------------------------------------------------------------
    always_comb begin
        w_pend = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (w_valid[i]) begin
                w_pend[w_entries[i].rd] = 1'b1;
            end
        end
    end

    // The FIFO state is only cleared at the end of the reset cycle, so the
    // visible status is forced to zero while reset is held.
    assign pend_mask  = rst ? '0 : w_pend;
    assign fifo_count = rst ? '0 : w_count;

endmodule : regfile_wb_arbiter
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Directed self-checking bench for regfile_wb_arbiter with
//               STARVE_LIMIT=4, FIFO_DEPTH=2. Inputs change on the falling
//               edge; outputs are checked 1 time unit later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_wr_valid;
    logic [4:0]  core_rd;
    logic [31:0] core_data;
    logic        core_stall;
    logic        aux_valid;
    logic [4:0]  aux_rd;
    logic [31:0] aux_data;
    logic        aux_ready;
    logic        ru_wr;
    logic [4:0]  ru_rd;
    logic [31:0] ru_data;
    logic [31:0] pend_mask;
    logic [1:0]  fifo_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(
        .STARVE_LIMIT (4),
        .FIFO_DEPTH   (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .core_wr_valid (core_wr_valid),
        .core_rd       (core_rd),
        .core_data     (core_data),
        .core_stall    (core_stall),
        .aux_valid     (aux_valid),
        .aux_rd        (aux_rd),
        .aux_data      (aux_data),
        .aux_ready     (aux_ready),
        .ru_wr         (ru_wr),
        .ru_rd         (ru_rd),
        .ru_data       (ru_data),
        .pend_mask     (pend_mask),
        .fifo_count    (fifo_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply one cycle's inputs on the falling edge, then let them settle.
    task automatic step(input logic r,
                        input logic cv, input logic [4:0] crd, input logic [31:0] cd,
                        input logic av, input logic [4:0] ard, input logic [31:0] ad);
        @(negedge clk);
        rst           = r;
        core_wr_valid = cv;
        core_rd       = crd;
        core_data     = cd;
        aux_valid     = av;
        aux_rd        = ard;
        aux_data      = ad;
        #1;
    endtask

    // Check the write port in one call.
    task automatic chk_port(input string tag, input logic w, input logic [4:0] rd,
                            input logic [31:0] d, input logic stall);
        chk({tag, ".ru_wr"},   {31'd0, ru_wr},      {31'd0, w});
        chk({tag, ".ru_rd"},   {27'd0, ru_rd},      {27'd0, rd});
        chk({tag, ".ru_data"}, ru_data,             d);
        chk({tag, ".stall"},   {31'd0, core_stall}, {31'd0, stall});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; core_wr_valid = 1'b0; core_rd = '0; core_data = '0;
        aux_valid = 1'b0; aux_rd = '0; aux_data = '0;

        // ---------------- Reset state (with active requests) ----------------
        step(1, 1, 5'd3, 32'h33, 1, 5'd4, 32'h44);
        step(1, 1, 5'd3, 32'h33, 1, 5'd4, 32'h44);
        chk_port("rst", 0, 0, 0, 0);
        chk("rst.aux_ready", {31'd0, aux_ready}, 0);
        chk("rst.pend",      pend_mask, 0);
        chk("rst.count",     {30'd0, fifo_count}, 0);

        // ---------------- Aux alone ----------------
        step(0, 0, 0, 0, 1, 5'd5, 32'hDEADBEEF);
        chk("aux1.ready", {31'd0, aux_ready}, 1);
        chk_port("aux1.c1", 0, 0, 0, 0);
        chk("aux1.pend.c1", pend_mask, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk_port("aux1.c2", 1, 5'd5, 32'hDEADBEEF, 0);
        chk("aux1.pend.c2", pend_mask, 32'h0000_0020);
        chk("aux1.count.c2", {30'd0, fifo_count}, 1);
        step(0, 0, 0, 0, 0, 0, 0);
        chk_port("aux1.c3", 0, 0, 0, 0);
        chk("aux1.pend.c3", pend_mask, 0);
        chk("aux1.count.c3", {30'd0, fifo_count}, 0);

        // ---------------- Starvation ----------------
        step(0, 1, 5'd1, 32'h101, 1, 5'd9, 32'h99);
        chk_port("stv.c0", 1, 5'd1, 32'h101, 0);
        for (int k = 1; k <= 4; k++) begin
            step(0, 1, 5'(k + 1), 32'h100 + 32'(k + 1), 0, 0, 0);
            chk_port($sformatf("stv.c%0d", k), 1, 5'(k + 1), 32'h100 + 32'(k + 1), 0);
            chk($sformatf("stv.pend.c%0d", k), pend_mask, 32'h0000_0200);
        end
        step(0, 1, 5'd6, 32'h106, 0, 0, 0);
        chk_port("stv.c5", 1, 5'd9, 32'h99, 1);
        step(0, 1, 5'd6, 32'h106, 0, 0, 0);
        chk_port("stv.c6", 1, 5'd6, 32'h106, 0);
        chk("stv.pend.c6", pend_mask, 0);

        // ---------------- Full / backpressure ----------------
        step(0, 1, 5'd1, 32'h201, 1, 5'd10, 32'hA0);
        chk("bp.c0.ready", {31'd0, aux_ready}, 1);
        step(0, 1, 5'd2, 32'h202, 1, 5'd11, 32'hB0);
        chk("bp.c1.ready", {31'd0, aux_ready}, 1);
        chk_port("bp.c1", 1, 5'd2, 32'h202, 0);
        step(0, 1, 5'd3, 32'h203, 1, 5'd12, 32'hC0);
        chk("bp.c2.ready", {31'd0, aux_ready}, 0);
        chk("bp.c2.count", {30'd0, fifo_count}, 2);
        chk("bp.c2.pend", pend_mask, 32'h0000_0C00);
        step(0, 1, 5'd4, 32'h204, 1, 5'd12, 32'hC0);
        chk_port("bp.c3", 1, 5'd4, 32'h204, 0);
        step(0, 1, 5'd5, 32'h205, 1, 5'd12, 32'hC0);
        chk_port("bp.c4", 1, 5'd5, 32'h205, 0);
        step(0, 1, 5'd6, 32'h206, 1, 5'd12, 32'hC0);
        chk_port("bp.c5", 1, 5'd10, 32'hA0, 1);
        chk("bp.c5.ready", {31'd0, aux_ready}, 0);
        step(0, 1, 5'd6, 32'h206, 1, 5'd12, 32'hC0);
        chk_port("bp.c6", 1, 5'd6, 32'h206, 0);
        chk("bp.c6.ready", {31'd0, aux_ready}, 1);
        chk("bp.c6.count", {30'd0, fifo_count}, 1);
        chk("bp.c6.pend", pend_mask, 32'h0000_0800);
        step(0, 0, 0, 0, 0, 0, 0);
        chk_port("bp.c7", 1, 5'd11, 32'hB0, 0);
        chk("bp.c7.pend", pend_mask, 32'h0000_1800);
        step(0, 0, 0, 0, 0, 0, 0);
        chk_port("bp.c8", 1, 5'd12, 32'hC0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("bp.c9.count", {30'd0, fifo_count}, 0);
        chk_port("bp.c9", 0, 0, 0, 0);

        // ---------------- x0 handling ----------------
        step(0, 0, 0, 0, 1, 5'd7, 32'h77);
        step(0, 1, 5'd0, 32'hFFFF, 0, 0, 0);
        chk_port("x0.core", 1, 5'd7, 32'h77, 0);
        chk("x0.pend", pend_mask, 32'h0000_0080);
        step(0, 0, 0, 0, 1, 5'd0, 32'h1234);
        chk("x0.aux.ready", {31'd0, aux_ready}, 1);
        chk_port("x0.aux.c0", 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("x0.aux.count", {30'd0, fifo_count}, 0);
        chk_port("x0.aux.c1", 0, 0, 0, 0);
        chk("x0.aux.pend", pend_mask, 0);

        // ---------------- Reset mid-operation ----------------
        step(0, 1, 5'd1, 32'h301, 1, 5'd20, 32'hE1);
        step(0, 1, 5'd2, 32'h302, 1, 5'd21, 32'hE2);
        step(0, 1, 5'd3, 32'h303, 0, 0, 0);
        step(0, 1, 5'd4, 32'h304, 0, 0, 0);
        chk("mid.count.pre", {30'd0, fifo_count}, 2);
        step(1, 1, 5'd5, 32'h305, 1, 5'd22, 32'hE3);
        chk_port("mid.rst", 0, 0, 0, 0);
        chk("mid.rst.ready", {31'd0, aux_ready}, 0);
        chk("mid.rst.pend",  pend_mask, 0);
        chk("mid.rst.count", {30'd0, fifo_count}, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk_port("mid.post", 0, 0, 0, 0);
        chk("mid.post.count", {30'd0, fifo_count}, 0);
        chk("mid.post.pend",  pend_mask, 0);
        chk("mid.post.ready", {31'd0, aux_ready}, 1);

        // ---------------- Push/pop at full, idle core ----------------
        step(0, 1, 5'd1, 32'h401, 1, 5'd13, 32'hD1);
        step(0, 1, 5'd2, 32'h402, 1, 5'd14, 32'hD2);
        step(0, 0, 0, 0, 1, 5'd15, 32'hD3);
        chk_port("pp.c2", 1, 5'd13, 32'hD1, 0);
        chk("pp.c2.ready", {31'd0, aux_ready}, 0);
        chk("pp.c2.count", {30'd0, fifo_count}, 2);
        step(0, 0, 0, 0, 1, 5'd15, 32'hD3);
        chk_port("pp.c3", 1, 5'd14, 32'hD2, 0);
        chk("pp.c3.count", {30'd0, fifo_count}, 1);
        step(0, 0, 0, 0, 0, 0, 0);
        chk_port("pp.c4", 1, 5'd15, 32'hD3, 0);
        chk("pp.c4.count", {30'd0, fifo_count}, 1);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("pp.c5.count", {30'd0, fifo_count}, 0);
        chk_port("pp.c5", 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_regfile_wb_arbiter
`default_nettype wire
